align_seq: RTL and testbench
============================

# align_seq

Sequencing controller for the 16-input PE alignment stage. It accepts one group of 16 signed mantissas with their exponents and finds the group maximum exponent. It then aligns every mantissa to that maximum through a shared LANES-wide arithmetic right shifter over 16/LANES cycles, and presents the aligned group to the adder tree with a valid/ready handshake. It sits between the product/exponent stage and the 16-input adder tree, replacing 16 parallel shifters with a time-multiplexed one.

## Interface
- WIDTH, 52: mantissa data is WIDTH+1 bits, signed two's complement.
- EXP_W, 10: exponent width, unsigned.
- LANES, 4: shifter lanes per beat; must divide 16 (legal values 1, 2, 4, 8, 16).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input group valid.
- in_ready  out  1  controller can accept a group.
- in_data  in  16*(WIDTH+1)  mantissa i at bits [i*(WIDTH+1) +: WIDTH+1].
- in_exp  in  16*EXP_W  exponent i at bits [i*EXP_W +: EXP_W].
- out_valid  out  1  aligned group valid.
- out_ready  in  1  consumer accepts the group.
- out_data  out  16*(WIDTH+1)  aligned mantissas, same packing as in_data.
- out_max_exp  out  EXP_W  group maximum exponent.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, MAX, SHIFT and OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and in_exp into the group registers and go to MAX.
- MAX: compute the 16-way unsigned maximum of the captured exponents and register it into max_exp. Clear beat counter. Go to SHIFT.
- SHIFT: beat b (0..16/LANES-1) processes elements b*LANES .. b*LANES+LANES-1.
  - Shift amount for element i is shamt_i = max_exp - exp_i, which is never negative.
  - If shamt_i > WIDTH, saturate it to WIDTH+1; the result is all sign bits.
  - Result is the arithmetic right shift of mantissa i, written back into the group register slot i.
  - After the last beat, go to OUT.
- OUT: out_valid=1. out_data and out_max_exp are driven from the registers and held stable while out_valid&&!out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid is ignored in every other state.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, out_max_exp=0, beat counter 0.
- Reset asserted in any state aborts the group with no partial output.

## Timing
- Input accepted at edge 0. MAX at cycle 1. SHIFT at cycles 2 .. 1+16/LANES. out_valid rises at cycle 2+16/LANES (cycle 6 for LANES=4).
- Output handshake at cycle N returns the FSM to IDLE at N+1. in_ready is high at N+1, so the minimum group period is 3+16/LANES cycles (7 for LANES=4).
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- ALIGN_STICKY_EN defined:
  - Each lane ORs all bits shifted out into result bit 0 (sticky).
  - For a saturated shift, the sticky bit is the OR of all non-sign-redundant input bits.
  - A zero shift leaves the value unchanged.
- ALIGN_STICKY_EN undefined: pure arithmetic shift; shifted-out bits are discarded.

## Structure
- Shared package align_pkg holds:
  - the state enum {IDLE, MAX, SHIFT, OUT};
  - NUM_IN=16;
  - SHAMT_W = $clog2(WIDTH+2);
  - BEATS = NUM_IN/LANES.
- Sub-module align_lane: one combinational lane (saturation, arithmetic shift, optional sticky), instantiated LANES times.
- The max tree and FSM live in align_seq.

## Test plan
- Equal exponents: all 16 exp=100, data i = i-8 → out_data identical to input, out_max_exp=100, out_valid at cycle 6.
- Mixed exponents: exp0=20, all others 17, data all 53'h0_0000_0000_0040 → element 0 unchanged, others 53'h8 (shift 3), out_max_exp=20.
- Negative and saturation: exp0=200, exp1=100, data1=-1 → out1=-1 (all ones); data1=+5 → out1=0; with ALIGN_STICKY_EN, data1=+5 → out1=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0, second in_valid ignored. Release out_ready → in_ready=1 next cycle, second group then accepted.
- Back-to-back: in_valid and out_ready held high for 3 groups → accepts exactly every 7 cycles, with 3 correct outputs in order.
- Reset mid-SHIFT: assert reset at cycle 3 → next cycle out_valid=0, busy=0, in_ready=1. A new group afterward completes correctly.

Source files
------------

// File: rtl/align_pkg.sv
// ---------------------------------------------------------------------------
// align_pkg
// Shared definitions for the PE alignment sequencer (align_seq) and its
// shifter lane (align_lane).
//   NUM_IN        : number of mantissa/exponent inputs per group (16)
//   state_e       : sequencer FSM states
//   calc_shamt_w  : width of a saturated shift amount (0 .. WIDTH+1)
//   calc_beats    : shifter beats per group for a given lane count
// Optional feature macro used by importers: ALIGN_STICKY_EN.
// ---------------------------------------------------------------------------
package align_pkg;

    localparam int unsigned NUM_IN = 16;

    typedef enum logic [1:0] {
        StIdle,
        StMax,
        StShift,
        StOut
    } state_e;

    // SHAMT_W = $clog2(WIDTH+2): enough to hold the saturated amount WIDTH+1.
    function automatic int unsigned calc_shamt_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    // BEATS = NUM_IN/LANES; LANES must divide NUM_IN (1, 2, 4, 8 or 16).
    function automatic int unsigned calc_beats(input int unsigned lanes);
        return NUM_IN / lanes;
    endfunction

endpackage

// File: rtl/align_lane.sv
// ---------------------------------------------------------------------------
// align_lane
// One combinational alignment lane: arithmetic right shift of a signed
// mantissa by (max_exp - exp), with the shift saturated at WIDTH+1 so an
// oversized shift yields pure sign bits.
// Config macro: ALIGN_STICKY_EN -- when defined, every bit shifted out is
// ORed into result bit 0 (sticky); otherwise shifted-out bits are dropped.
// Ports:
//   data_i     [WIDTH:0]   signed mantissa
//   exp_i      [EXP_W-1:0] this element's exponent
//   max_exp_i  [EXP_W-1:0] group maximum exponent (>= exp_i)
//   data_o     [WIDTH:0]   aligned mantissa
// ---------------------------------------------------------------------------
module align_lane import align_pkg::*; #(
    parameter int unsigned WIDTH = 52,
    parameter int unsigned EXP_W = 10
) (
    input  logic [WIDTH:0]   data_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [EXP_W-1:0] max_exp_i,
    output logic [WIDTH:0]   data_o
);

    localparam int unsigned DW      = WIDTH + 1;
    localparam int unsigned SHAMT_W = calc_shamt_w(WIDTH);

    logic [EXP_W-1:0]   diff;
    logic [SHAMT_W-1:0] shamt;
    logic [DW-1:0]      shifted;
`ifdef ALIGN_STICKY_EN
    logic [DW-1:0]      out_mask;
    logic               sticky;
`endif

    always_comb begin
        // max_exp_i is the group maximum, so the difference never wraps.
        diff = max_exp_i - exp_i;
        if (32'(diff) > WIDTH) begin
            shamt = SHAMT_W'(WIDTH + 1);
        end else begin
            shamt = SHAMT_W'(diff);
        end
        shifted = $signed(data_i) >>> shamt;
`ifdef ALIGN_STICKY_EN
        // (1 << shamt) - 1 wraps to all ones when shamt == DW, which is
        // exactly the saturated case where every input bit leaves the word.
        out_mask = (DW'(1) << shamt) - DW'(1);
        sticky   = |(data_i & out_mask);
        data_o   = {shifted[DW-1:1], shifted[0] | sticky};
`else
        data_o   = shifted;
`endif
    end

endmodule

// File: rtl/align_seq.sv
// ---------------------------------------------------------------------------
// align_seq
// Sequencing controller for the 16-input PE alignment stage. Captures one
// group of 16 signed mantissas plus exponents, finds the maximum exponent,
// aligns every mantissa to it through LANES shared shifter lanes over
// NUM_IN/LANES beats, then offers the aligned group with valid/ready.
// Config macro: ALIGN_STICKY_EN (sticky-bit shifting inside align_lane).
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset, aborts any group in flight
//   in_valid_i     input group valid
//   in_ready_o     high only while idle
//   in_data_i      16 mantissas, element i at [i*(WIDTH+1) +: WIDTH+1]
//   in_exp_i       16 exponents, element i at [i*EXP_W +: EXP_W]
//   out_valid_o    aligned group valid
//   out_ready_i    consumer accepts the group
//   out_data_o     aligned mantissas, same packing as in_data_i
//   out_max_exp_o  group maximum exponent
//   busy_o         high whenever not idle
// Timing (LANES=4): accept at edge 0, MAX in cycle 1, SHIFT in cycles 2..5,
// out_valid from cycle 6; minimum group period 3+NUM_IN/LANES cycles.
// ---------------------------------------------------------------------------
module align_seq import align_pkg::*; #(
    parameter int unsigned WIDTH = 52,
    parameter int unsigned EXP_W = 10,
    parameter int unsigned LANES = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NUM_IN*(WIDTH+1)-1:0]     in_data_i,
    input  logic [NUM_IN*EXP_W-1:0]         in_exp_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NUM_IN*(WIDTH+1)-1:0]     out_data_o,
    output logic [EXP_W-1:0]                out_max_exp_o,
    output logic                            busy_o
);

    localparam int unsigned DW     = WIDTH + 1;
    localparam int unsigned BEATS  = calc_beats(LANES);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_IN);

    state_e                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [NUM_IN-1:0][DW-1:0]     data_q, data_d;
    logic [NUM_IN-1:0][EXP_W-1:0]  exp_q, exp_d;
    logic [EXP_W-1:0]              max_q, max_d;

    // Heap-ordered max tree: node n has children 2n+1 and 2n+2, the leaves
    // sit at NUM_IN-1 .. 2*NUM_IN-2, and the root (node 0) is the maximum.
    logic [EXP_W-1:0]              tree [2*NUM_IN-1];

    logic [LANES-1:0][DW-1:0]      lane_in;
    logic [LANES-1:0][DW-1:0]      lane_out;
    logic [LANES-1:0][EXP_W-1:0]   lane_exp;
    logic [LANES-1:0][IDX_W-1:0]   lane_idx;

    // ------------------------------------------------------------------
    // Maximum exponent (unsigned compare)
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2 * NUM_IN - 1; i++) begin
            tree[i] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            tree[NUM_IN - 1 + i] = exp_q[i];
        end
        for (int n = NUM_IN - 2; n >= 0; n--) begin
            tree[n] = (tree[2*n+1] >= tree[2*n+2]) ? tree[2*n+1] : tree[2*n+2];
        end
    end

    // ------------------------------------------------------------------
    // Shared shifter lanes: beat b serves elements b*LANES .. b*LANES+LANES-1
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(int'(beat_q) * int'(LANES) + l);
        assign lane_in[l]  = data_q[lane_idx[l]];
        assign lane_exp[l] = exp_q[lane_idx[l]];

        align_lane #(
            .WIDTH (WIDTH),
            .EXP_W (EXP_W)
        ) u_lane (
            .data_i    (lane_in[l]),
            .exp_i     (lane_exp[l]),
            .max_exp_i (max_q),
            .data_o    (lane_out[l])
        );
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        data_d  = data_q;
        exp_d   = exp_q;
        max_d   = max_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    exp_d   = in_exp_i;
                    state_d = StMax;
                end
            end
            StMax: begin
                max_d   = tree[0];
                beat_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                // Aligned values overwrite their own slots in place.
                for (int l = 0; l < LANES; l++) begin
                    data_d[lane_idx[l]] = lane_out[l];
                end
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = StOut;
                end else begin
                    beat_d  = beat_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
            data_q  <= '0;
            exp_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            max_q   <= max_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, no input-to-output paths
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o    = (state_q == StIdle);
        out_valid_o   = (state_q == StOut);
        busy_o        = (state_q != StIdle);
        out_data_o    = data_q;
        out_max_exp_o = max_q;
    end

endmodule

// File: tb/tb_align_seq.sv
`timescale 1ns/1ps
module tb_align_seq;
    import align_pkg::*;

    localparam int unsigned WIDTH = 52;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = WIDTH + 1;
    localparam int unsigned BEATS = NUM_IN / LANES;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_IN*DW-1:0]        in_data;
    logic [NUM_IN*EXP_W-1:0]     in_exp;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_IN*DW-1:0]        out_data;
    logic [EXP_W-1:0]            out_max_exp;
    logic                        busy;

    align_seq #(
        .WIDTH (WIDTH),
        .EXP_W (EXP_W),
        .LANES (LANES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .in_exp_i      (in_exp),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_max_exp_o (out_max_exp),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_IN*DW-1:0] data;
        logic [EXP_W-1:0]     mx;
    } exp_t;

    exp_t             sb_q[$];
    logic [DW-1:0]    stim_d [NUM_IN];
    logic [EXP_W-1:0] stim_e [NUM_IN];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               acc_cyc = -1000;
    int               prev_acc = -1000;
    bit               rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Alignment as division: floor(v / 2^sh), sticky if the remainder is nonzero.
    function automatic logic [DW-1:0] ref_align(input logic [DW-1:0] d, input int unsigned sh);
        longint v, p, q, r;
        v = longint'($signed(d));
        if (sh > WIDTH) begin
            q = (v < 0) ? -64'sd1 : 64'sd0;
            r = v;
        end else begin
            p = longint'(1) << sh;
            if (v >= 0) q = v / p;
            else        q = -((-v + p - 1) / p);
            r = v - q * p;
        end
`ifdef ALIGN_STICKY_EN
        if (r != 0) q = q | 64'sd1;
`else
        if (r != 0) q = q;
`endif
        return q[DW-1:0];
    endfunction

    function automatic exp_t build_expect();
        exp_t        x;
        int unsigned m;
        m = 0;
        for (int i = 0; i < NUM_IN; i++) if (int'(stim_e[i]) > int'(m)) m = stim_e[i];
        x.mx = EXP_W'(m);
        for (int i = 0; i < NUM_IN; i++) x.data[i*DW +: DW] = ref_align(stim_d[i], m - stim_e[i]);
        return x;
    endfunction

    task automatic drive_stim();
        for (int i = 0; i < NUM_IN; i++) begin
            in_data[i*DW +: DW]     = stim_d[i];
            in_exp[i*EXP_W +: EXP_W] = stim_e[i];
        end
    endtask

    task automatic note_accept();
        sb_q.push_back(build_expect());
        prev_acc = acc_cyc;
        acc_cyc  = cyc + 1;
    endtask

    // Offer the current stimulus; returns just after the accepting edge.
    task automatic send(input bit keep_valid);
        drive_stim();
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            check("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            note_accept();
        end
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_group(input bit wide);
        int unsigned base;
        base = $urandom_range(0, (1 << EXP_W) - 1);
        for (int i = 0; i < NUM_IN; i++) begin
            if (wide) stim_e[i] = EXP_W'($urandom_range(0, (1 << EXP_W) - 1));
            else      stim_e[i] = EXP_W'(base > 8 ? base - $urandom_range(0, 8) : base);
            case ($urandom_range(0, 2))
                0:       stim_d[i] = DW'({$urandom(), $urandom()});
                1:       stim_d[i] = DW'($signed($urandom_range(0, 64)) - 32);
                default: stim_d[i] = DW'($urandom());
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: checks latency on every rising out_valid and pops the
    // scoreboard on every output handshake.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_valid) begin
                    check("latency", 64'(cyc - acc_cyc + 1), 64'(2 + BEATS));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        for (int i = 0; i < NUM_IN; i++) begin
                            check($sformatf("out_data[%0d]", i),
                                  64'(out_data[i*DW +: DW]), 64'(e.data[i*DW +: DW]));
                        end
                        check("out_max_exp", 64'(out_max_exp), 64'(e.mx));
                    end
                end
            end
            prev_valid = out_valid && !rst;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        exp_t a;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_exp    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_max_exp", 64'(out_max_exp), 64'd0);
        check("rst_out_data_zero", 64'(out_data == '0), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Equal exponents: identity
        for (int i = 0; i < NUM_IN; i++) begin
            stim_e[i] = EXP_W'(100);
            stim_d[i] = DW'(i - 8);
        end
        send(1'b0);
        drain();

        // Mixed exponents: shift by 3
        for (int i = 0; i < NUM_IN; i++) begin
            stim_e[i] = EXP_W'(i == 0 ? 20 : 17);
            stim_d[i] = DW'(64'h40);
        end
        send(1'b0);
        drain();

        // Saturation with negative and positive operands
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                stim_e[i] = EXP_W'(i == 1 ? 100 : 200);
                stim_d[i] = DW'({$urandom(), $urandom()});
            end
            stim_d[1] = (k == 0) ? {DW{1'b1}} : DW'(5);
            send(1'b0);
            drain();
        end

        // Extreme exponent spread
        for (int i = 0; i < NUM_IN; i++) begin
            stim_e[i] = EXP_W'(i == 5 ? (1 << EXP_W) - 1 : (i % 3) * 500);
            stim_d[i] = DW'({$urandom(), $urandom()});
        end
        send(1'b0);
        drain();

        // Backpressure: output held, second group ignored until release
        out_ready = 1'b0;
        rand_group(1'b0);
        send(1'b0);
        a = sb_q[0];
        for (int t = 0; t < 50; t++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        rand_group(1'b1);
        drive_stim();
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_out_stable", 64'(out_data == a.data), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("bp_after_in_ready", 64'(in_ready), 64'd1);
        note_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Back-to-back: in_valid and out_ready stay high
        for (int g = 0; g < 3; g++) begin
            rand_group(g == 1);
            send(1'b1);
            if (g > 0) check("b2b_period", 64'(acc_cyc - prev_acc), 64'(3 + BEATS));
        end
        in_valid = 1'b0;
        drain();

        // Reset in the middle of SHIFT
        rand_group(1'b0);
        send(1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        rand_group(1'b0);
        send(1'b0);
        drain();

        // Randomized groups with random output backpressure
        rand_rdy = 1'b1;
        for (int g = 0; g < 24; g++) begin
            rand_group(g % 4 == 3);
            send(1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
